universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg_if.sv | 34 +++
 rtl/universal_shift_reg.sv | 120 ++++++++++++
 tb/tb_universal_shift_reg.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/universal_shift_reg_if.sv
// Bundles the control, data and status signals of universal_shift_reg.
//   master: the side that drives controls/data and observes status (bench, parent)
//   slave : the shift register itself
// Signals: enable, mode[2:0], serial_in_l, serial_in_r, load, par_in[WIDTH],
//          start, count[CNT_W] (to slave); par_out[WIDTH], serial_out_msb,
//          serial_out_lsb, busy, done (from slave).
interface universal_shift_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             enable;
    logic [2:0]       mode;
    logic             serial_in_l;
    logic             serial_in_r;
    logic             load;
    logic [WIDTH-1:0] par_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] par_out;
    logic             serial_out_msb;
    logic             serial_out_lsb;
    logic             busy;
    logic             done;

    modport master (
        output enable, mode, serial_in_l, serial_in_r, load, par_in, start, count,
        input  par_out, serial_out_msb, serial_out_lsb, busy, done
    );

    modport slave (
        input  enable, mode, serial_in_l, serial_in_r, load, par_in, start, count,
        output par_out, serial_out_msb, serial_out_lsb, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register with manual single shifts and counted burst shifts.
// Ports:
//   clock - rising-edge clock for all state
//   reset - synchronous, active-high; clears register, FSM and burst count
//   bus   - universal_shift_reg_if.slave: enable, mode, serial_in_l/r, load,
//           par_in, start, count in; par_out, serial_out_msb/lsb, busy, done out
// Modes: 000 hold, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR, 110/111 hold.
module universal_shift_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    universal_shift_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ASR  = 3'b101
    } mode_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [2:0]       run_mode_q, run_mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] count_sat;

    function automatic logic [WIDTH-1:0] shift_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] r,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = r;
        case (m)
            MODE_SHL: res = {r[WIDTH-2:0], sl};
            MODE_SHR: res = {sr, r[WIDTH-1:1]};
            MODE_ROL: res = {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ROR: res = {r[0], r[WIDTH-1:1]};
            MODE_ASR: res = {r[WIDTH-1], r[WIDTH-1:1]};
            default:  res = r;  // hold, including the unused 110/111 codes
        endcase
        return res;
    endfunction

    // Requests longer than the register are clamped when latched.
    assign count_sat = (bus.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            run_mode_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            run_mode_q  <= run_mode_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        run_mode_d  = run_mode_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    reg_d = bus.par_in;
                end else if (bus.start) begin
                    // Latch-only edge: the burst's first shift happens in RUN.
                    run_mode_d  = bus.mode;
                    remaining_d = count_sat;
                    state_d     = (count_sat == '0) ? DONE : RUN;
                end else if (bus.enable) begin
                    reg_d = shift_op(bus.mode, reg_q, bus.serial_in_l, bus.serial_in_r);
                end
            end
            RUN: begin
                if (bus.load) begin
                    reg_d       = bus.par_in;
                    remaining_d = '0;
                    state_d     = IDLE;
                end else if (bus.enable) begin
                    reg_d       = shift_op(run_mode_q, reg_q, bus.serial_in_l, bus.serial_in_r);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.par_out        = reg_q;
    assign bus.serial_out_msb = reg_q[WIDTH-1];
    assign bus.serial_out_lsb = reg_q[0];
    assign bus.busy           = (state_q == RUN);
    assign bus.done           = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_ILL  = 3'b111;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   busy_cnt;
    int   done_cnt;

    universal_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and sample 1 time unit later, tallying status pulses.
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] val);
        bus.load   = 1'b1;
        bus.par_in = val;
        tick();
        bus.load   = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        busy_cnt = 0;
        done_cnt = 0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.mode        = M_HOLD;
        bus.serial_in_l = 1'b0;
        bus.serial_in_r = 1'b0;
        bus.load        = 1'b0;
        bus.par_in      = '0;
        bus.start       = 1'b0;
        bus.count       = '0;
        tick();
        tick();
        reset = 1'b0;
        chk8("reset_par_out", bus.par_out, 8'h00);
        chk1("reset_busy", bus.busy, 1'b0);
        chk1("reset_done", bus.done, 1'b0);

        // Parallel load and serial taps
        do_load(8'hA5);
        chk8("load_a5", bus.par_out, 8'hA5);
        chk1("load_msb", bus.serial_out_msb, 1'b1);
        chk1("load_lsb", bus.serial_out_lsb, 1'b1);

        // Manual rotates
        do_load(8'h81);
        bus.mode = M_ROL; bus.enable = 1'b1;
        tick();
        chk8("rol_1", bus.par_out, 8'h03);
        tick(); tick();
        chk8("rol_3", bus.par_out, 8'h0C);
        bus.mode = M_ROR;
        tick(); tick(); tick();
        chk8("ror_3", bus.par_out, 8'h81);

        // Manual SHL/SHR with serial inputs, then illegal mode holds
        bus.mode = M_SHL; bus.serial_in_l = 1'b1;
        tick();
        chk8("shl_sin1", bus.par_out, 8'h03);
        bus.mode = M_SHR; bus.serial_in_r = 1'b1;
        tick();
        chk8("shr_sin1", bus.par_out, 8'h81);
        bus.mode = M_ILL;
        tick();
        chk8("ill_hold", bus.par_out, 8'h81);
        bus.enable = 1'b0; bus.mode = M_SHL;
        tick();
        chk8("enable_low_hold", bus.par_out, 8'h81);
        bus.serial_in_l = 1'b0; bus.serial_in_r = 1'b0;

        // ASR burst of 3; mode change during RUN must be ignored
        do_load(8'h90);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_ASR; bus.count = 4'd3; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0; bus.mode = M_HOLD; bus.count = 4'd0;
        chk8("asr_start_noshift", bus.par_out, 8'h90);
        chk1("asr_busy_start", bus.busy, 1'b1);
        tick();
        chk8("asr_1", bus.par_out, 8'hC8);
        tick();
        chk8("asr_2", bus.par_out, 8'hE4);
        tick();
        chk8("asr_3", bus.par_out, 8'hF2);
        chk1("asr_done", bus.done, 1'b1);
        chk1("asr_busy_at_done", bus.busy, 1'b0);
        bus.enable = 1'b0;
        tick();
        chk1("asr_done_cleared", bus.done, 1'b0);
        chk8("asr_final_hold", bus.par_out, 8'hF2);
        chk8("asr_busy_cycles", 8'(busy_cnt), 8'd3);
        chk8("asr_done_cycles", 8'(done_cnt), 8'd1);

        // SHL burst of 4 with a 2-cycle enable stall
        do_load(8'h01);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_SHL; bus.count = 4'd4; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk8("stall_1", bus.par_out, 8'h02);
        tick();
        chk8("stall_2", bus.par_out, 8'h04);
        bus.enable = 1'b0;
        tick(); tick();
        chk8("stall_held", bus.par_out, 8'h04);
        chk1("stall_busy_held", bus.busy, 1'b1);
        bus.enable = 1'b1;
        tick();
        chk8("stall_3", bus.par_out, 8'h08);
        tick();
        chk8("stall_final", bus.par_out, 8'h10);
        chk1("stall_done", bus.done, 1'b1);
        bus.enable = 1'b0;
        tick();
        chk8("stall_busy_cycles", 8'(busy_cnt), 8'd6);
        chk8("stall_done_cycles", 8'(done_cnt), 8'd1);

        // Zero-length burst
        do_load(8'h3C);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_SHL; bus.count = 4'd0; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0; bus.enable = 1'b0;
        chk1("zero_done", bus.done, 1'b1);
        chk1("zero_busy", bus.busy, 1'b0);
        chk8("zero_par", bus.par_out, 8'h3C);
        tick();
        chk1("zero_done_cleared", bus.done, 1'b0);
        chk8("zero_busy_cycles", 8'(busy_cnt), 8'd0);

        // Count 9 saturates to 8: ROL 8 times returns to the start value
        do_load(8'h01);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_ROL; bus.count = 4'd9; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk8("sat_par", bus.par_out, 8'h01);
        chk1("sat_done", bus.done, 1'b1);
        chk8("sat_busy_cycles", 8'(busy_cnt), 8'd8);
        bus.enable = 1'b0;
        tick();

        // Illegal latched mode: full count with register held
        do_load(8'h5A);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_ILL; bus.count = 4'd2; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        chk8("ill_burst_par", bus.par_out, 8'h5A);
        chk1("ill_burst_done", bus.done, 1'b1);
        chk8("ill_burst_busy_cycles", 8'(busy_cnt), 8'd2);
        bus.enable = 1'b0;
        tick();

        // Reset during burst cycle 2
        do_load(8'h0F);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_SHL; bus.count = 4'd5; bus.enable = 1'b1;
        bus.serial_in_l = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk8("rst_burst_shift1", bus.par_out, 8'h1F);
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.enable = 1'b0; bus.serial_in_l = 1'b0;
        chk8("rst_burst_par", bus.par_out, 8'h00);
        chk1("rst_burst_busy", bus.busy, 1'b0);
        tick(); tick();
        chk8("rst_burst_no_done", 8'(done_cnt), 8'd0);
        chk1("rst_burst_idle", bus.busy, 1'b0);

        // Load during burst aborts without done
        do_load(8'h0F);
        busy_cnt = 0; done_cnt = 0;
        bus.start = 1'b1; bus.mode = M_ROR; bus.count = 4'd4; bus.enable = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk8("abort_shift1", bus.par_out, 8'h87);
        bus.load = 1'b1; bus.par_in = 8'hE7;
        tick();
        bus.load = 1'b0; bus.enable = 1'b0;
        chk8("abort_par", bus.par_out, 8'hE7);
        chk1("abort_busy", bus.busy, 1'b0);
        tick(); tick();
        chk8("abort_no_done", 8'(done_cnt), 8'd0);
        chk8("abort_hold", bus.par_out, 8'hE7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
